seq_bit_serializer: RTL

Upstream stage of the serial sequence detector. Accepts parallel words on a valid/ready handshake and emits them as a continuous one-bit-per-clock stream, MSB first, that drives the detector's serial `in` input directly. A one-word hold buffer lets back-to-back words stream with no idle gap. When no data is pending, the idle level is driven on the serial line.

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_ser_hold.sv | 33 +++
 rtl/seq_bit_serializer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence detector path: FSM state
// encoding and the default idle level of the serial line.
package seq_pkg;

  localparam int unsigned SEQ_STATE_W = 2;

  // Value 3 is unused; the serializer returns to IDLE if it is ever reached.
  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam logic SEQ_IDLE_LEVEL = 1'b0;

endpackage : seq_pkg

// File: rtl/seq_ser_hold.sv
// Single-entry prefetch buffer for the bit serializer. A word is pushed
// while the shifter is busy and popped when the current word finishes.
module seq_ser_hold #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] hold_word,
  output logic             hold_full,
  output logic             din_ready
);

  // Buffer storage and occupancy; push and pop are mutually exclusive
  // because push requires an empty buffer and pop a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_word <= '0;
      hold_full <= 1'b0;
    end else if (push) begin
      hold_word <= din;
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end

  // Ready depends only on the occupancy register, never on din_valid.
  assign din_ready = !hold_full;

endmodule : seq_ser_hold

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end of the sequence detector. Words are sent
// MSB first, one bit per clock, with a one-word hold buffer so that
// back-to-back words stream without a gap.
// Optional feature: define SEQ_SER_PARITY_EN to append an even-parity bit
// after each word (word_done then marks the parity bit).
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = SEQ_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic [1:0]       state
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] hold_word;
  logic             hold_full;
`ifdef SEQ_SER_PARITY_EN
  logic             par_q;
`endif

  logic             accept_c;
  logic             busy_c;
  logic             end_of_word_c;
  logic             drain_c;
  logic [WIDTH-1:0] load_word_c;

  // Handshake and buffer control decoded from registered state.
  assign accept_c    = din_valid && din_ready;
  assign busy_c      = (state_q != ST_IDLE);
  assign load_word_c = hold_full ? hold_word : din;
`ifdef SEQ_SER_PARITY_EN
  assign end_of_word_c = (state_q == ST_PARITY);
`else
  assign end_of_word_c = (state_q == ST_SHIFT) && (bit_cnt == '0);
`endif
  // A word left in hold while the FSM dropped to IDLE is drained from IDLE.
  assign drain_c = hold_full && (end_of_word_c || (state_q == ST_IDLE));

  // Prefetch buffer: filled only while a word is already shifting.
  seq_ser_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .push     (accept_c && busy_c),
    .pop      (drain_c),
    .hold_word(hold_word),
    .hold_full(hold_full),
    .din_ready(din_ready)
  );

  assign state = state_q;

  // Serializer FSM, shifter and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      word_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ser_out   <= IDLE_LEVEL;
          ser_valid <= 1'b0;
          if (hold_full || accept_c) begin
            shreg   <= load_word_c;
            bit_cnt <= CNT_LAST;
`ifdef SEQ_SER_PARITY_EN
            par_q   <= ^load_word_c;
`endif
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          ser_out   <= shreg[WIDTH-1];
          ser_valid <= 1'b1;
          shreg     <= {shreg[WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt - CNT_W'(1);
          if (bit_cnt == '0) begin
`ifdef SEQ_SER_PARITY_EN
            state_q <= ST_PARITY;
`else
            word_done <= 1'b1;
            if (hold_full) begin
              shreg   <= hold_word;
              bit_cnt <= CNT_LAST;
            end else begin
              state_q <= ST_IDLE;
            end
`endif
          end
        end
`ifdef SEQ_SER_PARITY_EN
        ST_PARITY: begin
          ser_out   <= par_q;
          ser_valid <= 1'b1;
          word_done <= 1'b1;
          if (hold_full) begin
            shreg   <= hold_word;
            bit_cnt <= CNT_LAST;
            par_q   <= ^hold_word;
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
`endif
        default: begin
          ser_out   <= IDLE_LEVEL;
          ser_valid <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : seq_bit_serializer
